// File: rtl/rf_pkg.sv
// Shared register-file types and constants for the writeback arbiter slice.
package rf_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef logic [AW-1:0]   rf_addr_t;
    typedef logic [XLEN-1:0] rf_data_t;

    localparam rf_addr_t REG_ZERO = '0;

    // Round-robin successor of a requester index, wrapping at n.
    function automatic logic [2:0] wrap_inc(input logic [2:0] i, input int unsigned n);
        if (int'(i) == int'(n) - 1) begin
            return 3'd0;
        end
        return i + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   ptr,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: round-robin among NREQ writeback sources, registered write.
// Optional macro RF_WB_BYPASS_EN adds two forwarding ports from the in-flight write.
module rf_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = rf_pkg::XLEN,
    parameter int AW   = rf_pkg::AW
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_rd,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 flush,
    output logic                 RegWrite,
    output logic [AW-1:0]        W_reg,
    output logic [XLEN-1:0]      W_data,
    output logic [2:0]           grant_idx
`ifdef RF_WB_BYPASS_EN
    ,
    input  logic [AW-1:0]        byp_raddr1,
    input  logic [AW-1:0]        byp_raddr2,
    output logic                 byp_hit1,
    output logic                 byp_hit2,
    output logic [XLEN-1:0]      byp_data1,
    output logic [XLEN-1:0]      byp_data2
`endif
);

    import rf_pkg::*;

    logic [2:0]      ptr_q, ptr_d;
    logic            regwrite_q, regwrite_d;
    logic [AW-1:0]   w_reg_q, w_reg_d;
    logic [XLEN-1:0] w_data_q, w_data_d;
    logic [2:0]      grant_idx_q, grant_idx_d;
    logic            arb_en;

    // Grants are suppressed while in reset so no transfer is signalled to a source.
    assign arb_en = ~flush & rstn;

    rr_arbiter #(.N(NREQ)) u_rr (
        .req (req_valid),
        .ptr (ptr_q),
        .en  (arb_en),
        .gnt (req_ready)
    );

    always_comb begin
        ptr_d       = ptr_q;
        regwrite_d  = 1'b0;
        w_reg_d     = w_reg_q;
        w_data_d    = w_data_q;
        grant_idx_d = grant_idx_q;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                w_reg_d     = req_rd[i*AW +: AW];
                w_data_d    = req_data[i*XLEN +: XLEN];
                // x0 is not hardwired in the register file, so drop its enable here.
                regwrite_d  = (req_rd[i*AW +: AW] != AW'(REG_ZERO));
                grant_idx_d = 3'(i);
                ptr_d       = wrap_inc(3'(i), NREQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q       <= '0;
            regwrite_q  <= 1'b0;
            w_reg_q     <= '0;
            w_data_q    <= '0;
            grant_idx_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            regwrite_q  <= regwrite_d;
            w_reg_q     <= w_reg_d;
            w_data_q    <= w_data_d;
            grant_idx_q <= grant_idx_d;
        end
    end

    assign RegWrite  = regwrite_q;
    assign W_reg     = w_reg_q;
    assign W_data    = w_data_q;
    assign grant_idx = grant_idx_q;

`ifdef RF_WB_BYPASS_EN
    // The register file reads and writes on the same edge, so forward the pending write.
    assign byp_hit1  = regwrite_q && (w_reg_q == byp_raddr1) && (w_reg_q != AW'(REG_ZERO));
    assign byp_hit2  = regwrite_q && (w_reg_q == byp_raddr2) && (w_reg_q != AW'(REG_ZERO));
    assign byp_data1 = w_data_q;
    assign byp_data2 = w_data_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, round robin, x0 filter, same-rd ordering, flush.
module tb_rf_wb_arbiter;

    localparam int NREQ = 3;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic                 clk;
    logic                 rstn;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_rd;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 flush;
    logic                 RegWrite;
    logic [AW-1:0]        W_reg;
    logic [XLEN-1:0]      W_data;
    logic [2:0]           grant_idx;
`ifdef RF_WB_BYPASS_EN
    logic [AW-1:0]        byp_raddr1, byp_raddr2;
    logic                 byp_hit1, byp_hit2;
    logic [XLEN-1:0]      byp_data1, byp_data2;
`endif

    int total;
    int bad;

    logic [XLEN-1:0] rf_model [32];

    rf_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .flush     (flush),
        .RegWrite  (RegWrite),
        .W_reg     (W_reg),
        .W_data    (W_data),
        .grant_idx (grant_idx)
`ifdef RF_WB_BYPASS_EN
        ,
        .byp_raddr1 (byp_raddr1),
        .byp_raddr2 (byp_raddr2),
        .byp_hit1   (byp_hit1),
        .byp_hit2   (byp_hit2),
        .byp_data1  (byp_data1),
        .byp_data2  (byp_data2)
`endif
    );

    // Clock and register-file model
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (RegWrite) rf_model[W_reg] <= W_data;
    end

    // Driver helpers: inputs change just after the falling edge
    task automatic set_req(input int i, input logic v, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
        req_valid[i]            = v;
        req_rd[i*AW +: AW]      = rd;
        req_data[i*XLEN +: XLEN] = d;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        req_rd    = '0;
        req_data  = '0;
        set_req(0, 1'b1, 5'd1, 32'h0000_1111);
        set_req(1, 1'b1, 5'd2, 32'h0000_2222);
        set_req(2, 1'b1, 5'd3, 32'h0000_3333);
        repeat (3) next_cycle();
        #1;
        total++; if (RegWrite !== 1'b0) begin $display("FAIL reset_regwrite got=%0b want=0", RegWrite); bad++; end
        total++; if (W_reg !== 5'd0) begin $display("FAIL reset_w_reg got=%0d want=0", W_reg); bad++; end
        total++; if (W_data !== 32'h0) begin $display("FAIL reset_w_data got=%h want=0", W_data); bad++; end
        total++; if (grant_idx !== 3'd0) begin $display("FAIL reset_grant_idx got=%0d want=0", grant_idx); bad++; end
        total++; if (req_ready !== 3'b000) begin $display("FAIL reset_ready got=%b want=000", req_ready); bad++; end
        rstn = 1'b1;
        #1;
        total++; if (req_ready !== 3'b001) begin $display("FAIL reset_first_ready got=%b want=001", req_ready); bad++; end
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_gnt [4];
        logic [AW-1:0] exp_rd [4];
        exp_gnt[0] = 3'b001; exp_gnt[1] = 3'b010; exp_gnt[2] = 3'b100; exp_gnt[3] = 3'b001;
        exp_rd[0]  = 5'd1;   exp_rd[1]  = 5'd2;   exp_rd[2]  = 5'd3;   exp_rd[3]  = 5'd1;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            req_valid = 3'b111;
            #1;
            total++; if (req_ready !== exp_gnt[k]) begin $display("FAIL rr_ready[%0d] got=%b want=%b", k, req_ready, exp_gnt[k]); bad++; end
            if (k > 0) begin
                total++; if (W_reg !== exp_rd[k-1]) begin $display("FAIL rr_w_reg[%0d] got=%0d want=%0d", k, W_reg, exp_rd[k-1]); bad++; end
                total++; if (RegWrite !== 1'b1) begin $display("FAIL rr_regwrite[%0d] got=%0b want=1", k, RegWrite); bad++; end
            end
        end
        next_cycle();
        req_valid = '0;
        #1;
        total++; if (W_reg !== 5'd1 || RegWrite !== 1'b1 || grant_idx !== 3'd0) begin
            $display("FAIL rr_last_write got=rd%0d/we%0b/g%0d want=rd1/we1/g0", W_reg, RegWrite, grant_idx); bad++; end
        next_cycle();
        #1;
        total++; if (RegWrite !== 1'b0 || W_reg !== 5'd1 || W_data !== 32'h0000_1111) begin
            $display("FAIL rr_idle_hold got=we%0b/rd%0d/%h want=we0/rd1/00001111", RegWrite, W_reg, W_data); bad++; end
    endtask

    // Pointer is 1 on entry
    task automatic test_x0();
        set_req(0, 1'b1, 5'd0, 32'hDEAD_BEEF);
        #1;
        total++; if (req_ready !== 3'b001) begin $display("FAIL x0_ready got=%b want=001", req_ready); bad++; end
        next_cycle();
        set_req(0, 1'b0, 5'd0, 32'h0);
        set_req(1, 1'b1, 5'd5, 32'h0000_1234);
        #1;
        total++; if (RegWrite !== 1'b0) begin $display("FAIL x0_regwrite got=%0b want=0", RegWrite); bad++; end
        total++; if (grant_idx !== 3'd0) begin $display("FAIL x0_grant_idx got=%0d want=0", grant_idx); bad++; end
        total++; if (req_ready !== 3'b010) begin $display("FAIL x0_next_ready got=%b want=010", req_ready); bad++; end
        next_cycle();
        req_valid = '0;
        #1;
        total++; if (W_reg !== 5'd5 || W_data !== 32'h0000_1234 || RegWrite !== 1'b1) begin
            $display("FAIL x0_r5_write got=rd%0d/%h/we%0b want=rd5/00001234/we1", W_reg, W_data, RegWrite); bad++; end
    endtask

    // Pointer is 2 on entry
    task automatic test_same_rd();
        next_cycle();
        set_req(0, 1'b1, 5'd7, 32'hAAAA_0000);
        set_req(2, 1'b1, 5'd7, 32'hBBBB_0000);
        #1;
        total++; if (req_ready !== 3'b100) begin $display("FAIL same_rd_ready got=%b want=100", req_ready); bad++; end
        next_cycle();
        set_req(2, 1'b0, 5'd7, 32'hBBBB_0000);
        #1;
        total++; if (W_reg !== 5'd7 || W_data !== 32'hBBBB_0000 || RegWrite !== 1'b1) begin
            $display("FAIL same_rd_first got=rd%0d/%h/we%0b want=rd7/bbbb0000/we1", W_reg, W_data, RegWrite); bad++; end
        total++; if (req_ready !== 3'b001) begin $display("FAIL same_rd_second_ready got=%b want=001", req_ready); bad++; end
        next_cycle();
        req_valid = '0;
        #1;
        total++; if (W_data !== 32'hAAAA_0000 || RegWrite !== 1'b1) begin
            $display("FAIL same_rd_second got=%h/we%0b want=aaaa0000/we1", W_data, RegWrite); bad++; end
        next_cycle();
        #1;
        total++; if (rf_model[7] !== 32'hAAAA_0000) begin $display("FAIL same_rd_final got=%h want=aaaa0000", rf_model[7]); bad++; end
    endtask

    // Pointer is 1 on entry
    task automatic test_flush();
        set_req(0, 1'b1, 5'd10, 32'h0000_00A0);
        set_req(1, 1'b1, 5'd11, 32'h0000_00B0);
        set_req(2, 1'b1, 5'd12, 32'h0000_00C0);
        #1;
        total++; if (req_ready !== 3'b010) begin $display("FAIL flush_pre_ready got=%b want=010", req_ready); bad++; end
        next_cycle();
        set_req(1, 1'b0, 5'd11, 32'h0000_00B0);
        flush = 1'b1;
        #1;
        total++; if (req_ready !== 3'b000) begin $display("FAIL flush_ready0 got=%b want=000", req_ready); bad++; end
        total++; if (RegWrite !== 1'b1 || W_reg !== 5'd11) begin
            $display("FAIL flush_inflight got=we%0b/rd%0d want=we1/rd11", RegWrite, W_reg); bad++; end
        next_cycle();
        #1;
        total++; if (req_ready !== 3'b000 || RegWrite !== 1'b0) begin
            $display("FAIL flush_cycle2 got=rdy%b/we%0b want=rdy000/we0", req_ready, RegWrite); bad++; end
        next_cycle();
        flush = 1'b0;
        #1;
        total++; if (RegWrite !== 1'b0) begin $display("FAIL flush_after_we got=%0b want=0", RegWrite); bad++; end
        total++; if (req_ready !== 3'b100) begin $display("FAIL flush_resume_ready got=%b want=100", req_ready); bad++; end
        next_cycle();
        req_valid = '0;
        #1;
        total++; if (W_reg !== 5'd12 || W_data !== 32'h0000_00C0 || RegWrite !== 1'b1 || grant_idx !== 3'd2) begin
            $display("FAIL flush_resume_write got=rd%0d/%h/we%0b/g%0d want=rd12/000000c0/we1/g2", W_reg, W_data, RegWrite, grant_idx); bad++; end
    endtask

`ifdef RF_WB_BYPASS_EN
    task automatic test_bypass();
        byp_raddr1 = 5'd9;
        byp_raddr2 = 5'd0;
        next_cycle();
        set_req(1, 1'b1, 5'd9, 32'h0000_0055);
        next_cycle();
        req_valid = '0;
        #1;
        total++; if (byp_hit1 !== 1'b1 || byp_data1 !== 32'h0000_0055) begin
            $display("FAIL byp_hit1 got=%0b/%h want=1/00000055", byp_hit1, byp_data1); bad++; end
        total++; if (byp_hit2 !== 1'b0) begin $display("FAIL byp_hit2 got=%0b want=0", byp_hit2); bad++; end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        for (int r = 0; r < 32; r++) rf_model[r] = '0;
`ifdef RF_WB_BYPASS_EN
        byp_raddr1 = '0;
        byp_raddr2 = '0;
`endif
        test_reset();
        test_round_robin();
        test_x0();
        test_same_rd();
        test_flush();
`ifdef RF_WB_BYPASS_EN
        test_bypass();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
